fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one 64-entry x 8-bit fifo between NUM_REQ producers.

---
 rtl/fifo_wr_arbiter_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo write arbiter.
//   - default fifo geometry (depth, data width, counter width)
//   - arbiter FSM state encoding
//   - index wrap helper used for round-robin pointers
package fifo_wr_arbiter_pkg;

    localparam int DEF_DEPTH  = 64;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Next index in a ring of n entries: n-1 wraps to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority requester select.
// Ports:
//   req     in   NUM_REQ         request vector
//   rr_base in   clog2(NUM_REQ)  highest-priority index this round
//   idx     out  clog2(NUM_REQ)  first requester at/after rr_base (wrapping)
//   found   out  1               any request present
module fifo_wr_arbiter_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_base,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       found
);

    localparam int OW = $clog2(NUM_REQ);

    function automatic int slot(input int base, input int k);
        return (base + k) % NUM_REQ;
    endfunction

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan from rr_base upward; the first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[slot(int'(rr_base), k)]) begin
                found = 1'b1;
                idx   = OW'(slot(int'(rr_base), k));
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one fifo write port between NUM_REQ
// producers. A producer is granted for a burst of up to MAX_BURST words,
// after which priority rotates to the next index. Writes are throttled on
// fifo occupancy so the fifo is never written while full.
//
// Handshake: a producer holds req[i] high with its word on
// req_data[i*DATA_W +: DATA_W]; ack[i] pulses for exactly the cycles in which
// that word is taken. After an ack the producer presents its next word or
// drops req. Dropping req without an ack withdraws the word and ends the
// burst. One idle (arbitration) cycle separates consecutive bursts.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   req          in   per-producer request
//   req_data     in   flattened producer words
//   ack          out  one-hot word-accepted pulse (combinational)
//   owner        out  current/last granted producer
//   busy         out  high while a burst is in progress
//   fifo_counter in   fifo occupancy
//   overflow     in   fifo full flag
//   wr_en        out  fifo write enable (registered)
//   data_in      out  fifo write data (registered)
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    input  logic [CNT_W-1:0]            fifo_counter,
    input  logic                        overflow,
    output logic                        wr_en,
    output logic [DATA_W-1:0]           data_in
);

    localparam int OW   = $clog2(NUM_REQ);
    localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_e            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_base_q, rr_base_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;

    logic [OW-1:0]     pick_idx;
    logic              pick_found;
    logic [CNT_W:0]    occ;
    logic              space_ok;
    logic              owner_req;
    logic [DATA_W-1:0] owner_data;
    logic              grant;
    logic              last_beat;
    logic [OW-1:0]     owner_next;

    fifo_wr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (req),
        .rr_base (rr_base_q),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    // The word sitting in wr_en_q has not reached fifo_counter yet, so it is
    // counted here; this is conservative by one cycle when the fifo is also
    // being read.
    assign occ        = {1'b0, fifo_counter} + {{CNT_W{1'b0}}, wr_en_q};
    assign space_ok   = (occ < (CNT_W+1)'(DEPTH)) && !overflow;

    assign owner_req  = req[owner_q];
    assign owner_data = req_data[owner_q*DATA_W +: DATA_W];
    assign grant      = (state_q == ST_BURST) && owner_req && space_ok;
    assign last_beat  = (burst_cnt_q == BC_W'(MAX_BURST - 1));
    assign owner_next = OW'(wrap_inc(int'(owner_q), NUM_REQ));

    always_comb begin
        ack = '0;
        if (grant) begin
            ack[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_base_d   = rr_base_q;
        burst_cnt_d = burst_cnt_q;
        wr_en_d     = 1'b0;
        data_in_d   = data_in_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found && space_ok) begin
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (grant) begin
                    wr_en_d     = 1'b1;
                    data_in_d   = owner_data;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // A full burst or a withdrawn request hands priority on.
                // A stall on space keeps ownership.
                if ((grant && last_beat) || !owner_req) begin
                    state_d     = ST_IDLE;
                    rr_base_d   = owner_next;
                    burst_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_base_q   <= '0;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            data_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_base_q   <= rr_base_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            data_in_q   <= data_in_d;
        end
    end

    assign owner   = owner_q;
    assign busy    = (state_q == ST_BURST);
    assign wr_en   = wr_en_q;
    assign data_in = data_in_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a simple fifo occupancy model, four
// producer word lists and an expected-write queue.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 64;
    localparam int CNT_W     = 8;
    localparam int MAX_BURST = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [1:0]                owner;
    logic                      busy;
    logic [CNT_W-1:0]          fifo_counter;
    logic                      overflow;
    logic                      wr_en;
    logic [DATA_W-1:0]         data_in;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .owner        (owner),
        .busy         (busy),
        .fifo_counter (fifo_counter),
        .overflow     (overflow),
        .wr_en        (wr_en),
        .data_in      (data_in)
    );

    // ---------------- fifo model / producers / scoreboard ----------------
    int   fcnt;
    logic rd;
    assign fifo_counter = 8'(fcnt);
    assign overflow     = (fcnt >= DEPTH);

    logic [7:0] src_mem [4][16];
    int         src_rd [4];
    int         src_n  [4];
    logic [DATA_W-1:0] exp_q[$];

    int checks   = 0;
    int failures = 0;

    logic [3:0] ack_s;
    logic       wr_s;
    logic [7:0] d_s;
    logic       busy_s;
    logic [1:0] owner_s;

    // Hand-derived per-cycle ack vectors (cycle 1 = first cycle with req).
    logic [3:0] t2_ack [11] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0,
                                4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
    int         t3_own [5]  = '{0, 1, 2, 3, 0};
    logic [3:0] t4_ack [21] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4,
                                4'h0, 4'h8, 4'h8, 4'h8, 4'h8,
                                4'h0, 4'h1, 4'h1, 4'h1, 4'h1,
                                4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
    logic [3:0] t5_ack [8]  = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] t6_ack [15] = '{4'h0, 4'h1, 4'h1, 4'h0,
                                4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
                                4'h1, 4'h1, 4'h1, 4'h1, 4'h0};

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_rd[i] < src_n[i]) begin
                req[i]              = 1'b1;
                req_data[i*8 +: 8]  = src_mem[i][src_rd[i]];
            end else begin
                req[i]              = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
            end
        end
    endtask

    task automatic push(input int p, input logic [7:0] w);
        src_mem[p][src_n[p]] = w;
        src_n[p]++;
    endtask

    // One clock cycle: observe mid-cycle, then apply the edge to the fifo
    // model and producers and drive the next cycle's inputs.
    task automatic step();
        @(negedge clk);
        ack_s   = ack;
        wr_s    = wr_en;
        d_s     = data_in;
        busy_s  = busy;
        owner_s = owner;
        chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
        chk("no_write_when_full", 32'(wr_en && overflow), 32'd0);
        @(posedge clk);
        #1;
        if (wr_s) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("write_data", 32'(d_s), 32'(exp_q.pop_front()));
            end
            fcnt++;
        end
        if (rd && fcnt > 0) fcnt--;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_s[i]) src_rd[i]++;
        end
        drive();
    endtask

    // Step and compare against a hand-computed ack vector; whenever a word is
    // expected, the burst must be active and owned by that producer.
    task automatic run_cycle(input string tag, input int s, input logic [3:0] exp_ack);
        step();
        chk($sformatf("%s_ack[%0d]", tag, s), 32'(ack_s), 32'(exp_ack));
        if (exp_ack != 4'h0) begin
            chk($sformatf("%s_busy[%0d]", tag, s), 32'(busy_s), 32'd1);
            chk($sformatf("%s_owner[%0d]", tag, s), 32'(owner_s), 32'(idx_of(exp_ack)));
        end
    endtask

    task automatic arb_reset();
        reset = 1'b0;
        rd    = 1'b0;
        fcnt  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_rd[i] = 0;
            src_n[i]  = 0;
        end
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        req      = '0;
        req_data = '0;
        arb_reset();
        reset = 1'b0;
        #1;
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        chk("reset_data_in", 32'(data_in), 32'd0);

        // Single producer 2, eight words: 4 acks, bubble, 4 acks.
        arb_reset();
        for (int k = 0; k < 8; k++) begin
            push(2, 8'(8'h10 + k));
            exp_q.push_back(8'(8'h10 + k));
        end
        drive();
        for (int s = 0; s < 11; s++) begin
            run_cycle("t2", s, t2_ack[s]);
            if (s == 1) chk("t2_wr_en_before_latency", 32'(wr_s), 32'd0);
            if (s == 2) chk("t2_wr_en_at_latency", 32'(wr_s), 32'd1);
        end
        chk("t2_fifo_count", 32'(fcnt), 32'd8);
        chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);

        // All four request from reset: owners 0,1,2,3,0, four words each.
        arb_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h00 + k));
        for (int p = 1; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                push(p, 8'(p * 16 + k));
                exp_q.push_back(8'(p * 16 + k));
            end
        end
        for (int k = 0; k < 8; k++) push(0, 8'(8'h00 + k));
        for (int k = 4; k < 8; k++) exp_q.push_back(8'(8'h00 + k));
        drive();
        for (int s = 0; s < 26; s++) begin
            run_cycle("t3", s, (s % 5 == 0) ? 4'h0 : 4'(4'h1 << t3_own[s / 5]));
        end
        chk("t3_fifo_count", 32'(fcnt), 32'd20);
        chk("t3_sb_drained", 32'(exp_q.size()), 32'd0);

        // Wrap: one burst of producer 2 leaves rr_base=3, then 3 and 0 compete.
        arb_reset();
        for (int k = 0; k < 4; k++) begin
            push(2, 8'(8'hA0 + k));
            exp_q.push_back(8'(8'hA0 + k));
        end
        drive();
        for (int s = 0; s < 5; s++) run_cycle("t4", s, t4_ack[s]);
        for (int k = 0; k < 4; k++) begin
            push(3, 8'(8'hB0 + k));
            exp_q.push_back(8'(8'hB0 + k));
        end
        for (int k = 0; k < 8; k++) begin
            push(0, 8'(8'hC0 + k));
            exp_q.push_back(8'(8'hC0 + k));
        end
        drive();
        for (int s = 5; s < 21; s++) run_cycle("t4", s, t4_ack[s]);
        chk("t4_fifo_count", 32'(fcnt), 32'd16);
        chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);

        // Near-full fifo: 62 words preloaded, only two of four accepted.
        arb_reset();
        fcnt = 62;
        for (int k = 0; k < 4; k++) push(1, 8'(8'h50 + k));
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h51);
        drive();
        for (int s = 0; s < 8; s++) run_cycle("t5", s, t5_ack[s]);
        chk("t5_stall_busy", 32'(busy_s), 32'd1);
        chk("t5_stall_owner", 32'(owner_s), 32'd1);
        chk("t5_full_count", 32'(fcnt), 32'd64);
        rd = 1'b1;
        run_cycle("t5_read", 0, 4'h0);
        rd = 1'b0;
        run_cycle("t5_read", 1, 4'h2);
        chk("t5_sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-burst while a word sits in the write register: dropped.
        chk("t1_pre_wr_en", 32'(wr_en), 32'd1);
        chk("t1_pre_data_in", 32'(data_in), 32'h52);
        chk("t1_pre_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("t1_wr_en", 32'(wr_en), 32'd0);
        chk("t1_ack", 32'(ack), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_owner", 32'(owner), 32'd0);
        chk("t1_fifo_count", 32'(fcnt), 32'd63);

        // Withdraw: producer 0 drops req after two words.
        arb_reset();
        push(0, 8'h60);
        push(0, 8'h61);
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h61);
        drive();
        for (int s = 0; s < 4; s++) run_cycle("t6", s, t6_ack[s]);
        chk("t6_withdraw_busy", 32'(busy_s), 32'd1);
        for (int k = 0; k < 4; k++) begin
            push(0, 8'(8'h70 + k));
            push(1, 8'(8'h80 + k));
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h80 + k));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h70 + k));
        drive();
        for (int s = 4; s < 15; s++) begin
            run_cycle("t6", s, t6_ack[s]);
            if (s == 4) begin
                chk("t6_idle_after_withdraw", 32'(busy_s), 32'd0);
                chk("t6_owner_kept", 32'(owner_s), 32'd0);
            end
        end
        chk("t6_fifo_count", 32'(fcnt), 32'd10);
        chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
